md_unit: RTL



---
 rtl/md_unit.sv | 136 +++++++++++++
 1 files changed

// File: rtl/md_unit.sv
// Iterative 32-bit multiply/divide unit holding the MIPS HI/LO registers.
// One operand-latch cycle, 32 shift-add / restoring-divide iterations, one sign-fix cycle.
module md_unit (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [1:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_mthi,
    input  logic        i_mtlo,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo,
    output logic        o_busy,
    output logic        o_done
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t      r_state, w_next;
    logic [4:0]  r_cnt;
    logic        r_is_div, r_sgn_q, r_sgn_r, r_bzero;
    logic [31:0] r_opnd;
    logic [63:0] r_acc;
    logic [31:0] r_rem;
    logic [31:0] r_hi, r_lo;
    logic        r_busy, r_done;

    logic        w_signed, w_a_neg, w_b_neg, w_op_div;
    logic [31:0] w_a_mag, w_b_mag;
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_nxt;
    logic [32:0] w_div_sh, w_div_dif;
    logic        w_div_ge;
    logic [31:0] w_div_rem, w_div_quo;
    logic [63:0] w_prod;
    logic [31:0] w_quo, w_rem;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_CALC;
            S_CALC:  if (r_cnt == 5'd31) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Operand conditioning: signed ops work on magnitudes
    assign w_op_div = i_op[1];
    assign w_signed = ~i_op[0];
    assign w_a_neg  = w_signed & i_a[31];
    assign w_b_neg  = w_signed & i_b[31];
    assign w_a_mag  = w_a_neg ? -i_a : i_a;
    assign w_b_mag  = w_b_neg ? -i_b : i_b;

    assign w_mul_sum = r_acc[0] ? ({1'b0, r_acc[63:32]} + {1'b0, r_opnd}) : {1'b0, r_acc[63:32]};
    assign w_mul_nxt = {w_mul_sum, r_acc[31:1]};

    // 33-bit partial remainder: previous remainder shifted with the next dividend bit
    assign w_div_sh  = {r_rem, r_acc[31]};
    assign w_div_dif = w_div_sh - {1'b0, r_opnd};
    assign w_div_ge  = (w_div_sh >= {1'b0, r_opnd});
    assign w_div_rem = w_div_ge ? w_div_dif[31:0] : w_div_sh[31:0];
    assign w_div_quo = {r_acc[30:0], w_div_ge};

    // Divide by zero leaves |a| in the remainder, so HI already equals raw a after sign fix
    assign w_prod = r_sgn_q ? -r_acc : r_acc;
    assign w_quo  = r_bzero ? 32'hFFFF_FFFF : (r_sgn_q ? -r_acc[31:0] : r_acc[31:0]);
    assign w_rem  = r_sgn_r ? -r_rem : r_rem;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_sgn_q  <= 1'b0;
            r_sgn_r  <= 1'b0;
            r_bzero  <= 1'b0;
            r_opnd   <= '0;
            r_acc    <= '0;
            r_rem    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_cnt    <= '0;
                        r_is_div <= w_op_div;
                        r_sgn_q  <= w_a_neg ^ w_b_neg;
                        r_sgn_r  <= w_a_neg;
                        r_bzero  <= (i_b == 32'd0);
                        r_opnd   <= w_op_div ? w_b_mag : w_a_mag;
                        r_acc    <= {32'd0, (w_op_div ? w_a_mag : w_b_mag)};
                        r_rem    <= '0;
                        r_busy   <= 1'b1;
                    end else begin
                        if (i_mthi) r_hi <= i_wdata;
                        if (i_mtlo) r_lo <= i_wdata;
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + 5'd1;
                    if (r_is_div) begin
                        r_rem        <= w_div_rem;
                        r_acc[31:0]  <= w_div_quo;
                    end else begin
                        r_acc <= w_mul_nxt;
                    end
                end
                S_FIX: begin
                    r_hi   <= r_is_div ? w_rem : w_prod[63:32];
                    r_lo   <= r_is_div ? w_quo : w_prod[31:0];
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign o_hi   = r_hi;
    assign o_lo   = r_lo;
    assign o_busy = r_busy;
    assign o_done = r_done;

endmodule
